// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard_if
// Description : Bundle between the ID stage / writeback path and the hazard
//               scoreboard.
//               Ports seen from the scoreboard (slave modport):
//                 ID_issue              in  instruction in ID advances to ID/EX
//                 ID_rs1 / ID_rs2       in  source registers of the ID instruction
//                 ID_useRs1 / ID_useRs2 in  source register actually read
//                 ID_rd                 in  destination register of the ID instruction
//                 ID_regWrite           in  ID instruction writes rd
//                 ID_memRead            in  ID instruction is a load
//                 ID_longOp             in  ID instruction is multi-cycle (div/rem)
//                 flush_ex              in  instruction in ID/EX is squashed
//                 WB_regWrite / WB_rd   in  register write retiring this cycle
//                 stall                 out hold PC/IF_ID, bubble ID/EX
//                 stall_cause           out 00 none, 01 load-use, 10 long-op, 11 saturated
//                 busy_vec              out per-register outstanding-writer flag
//                 sb_err                out sticky writeback-without-writer error
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_scoreboard_if #(
    parameter int NREG = 32
);
    logic            ID_issue;
    logic [4:0]      ID_rs1;
    logic [4:0]      ID_rs2;
    logic            ID_useRs1;
    logic            ID_useRs2;
    logic [4:0]      ID_rd;
    logic            ID_regWrite;
    logic            ID_memRead;
    logic            ID_longOp;
    logic            flush_ex;
    logic            WB_regWrite;
    logic [4:0]      WB_rd;
    logic            stall;
    logic [1:0]      stall_cause;
    logic [NREG-1:0] busy_vec;
    logic            sb_err;

    // Pipeline side: drives the ID/WB information, consumes the stall.
    modport master (
        output ID_issue, ID_rs1, ID_rs2, ID_useRs1, ID_useRs2, ID_rd,
               ID_regWrite, ID_memRead, ID_longOp, flush_ex, WB_regWrite, WB_rd,
        input  stall, stall_cause, busy_vec, sb_err
    );

    // Scoreboard side.
    modport slave (
        input  ID_issue, ID_rs1, ID_rs2, ID_useRs1, ID_useRs2, ID_rd,
               ID_regWrite, ID_memRead, ID_longOp, flush_ex, WB_regWrite, WB_rd,
        output stall, stall_cause, busy_vec, sb_err
    );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : hazard_scoreboard
// Description : Tracks every in-flight register write from issue to writeback
//               and stalls ID when forwarding cannot supply a source operand
//               (load-use, long-latency RAW/WAW) or when a register's
//               outstanding-writer counter would overflow.
//               Ports: clk, reset_n (synchronous, active-low) and the slave
//               side of hazard_scoreboard_if (see that file for the list).
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_scoreboard #(
    parameter int NREG   = 32,
    parameter int PEND_W = 2
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    hazard_scoreboard_if.slave sb
);

    // Per-register kind encoding
    localparam logic [1:0] c_FREE = 2'd0;
    localparam logic [1:0] c_FWD  = 2'd1;
    localparam logic [1:0] c_LOAD = 2'd2;
    localparam logic [1:0] c_LONG = 2'd3;

    localparam logic [1:0] c_CAUSE_NONE = 2'b00;
    localparam logic [1:0] c_CAUSE_LOAD = 2'b01;
    localparam logic [1:0] c_CAUSE_LONG = 2'b10;
    localparam logic [1:0] c_CAUSE_SAT  = 2'b11;

    // Two guard bits: one for the +1 overflow, one as sign for the -2 underflow.
    localparam int c_SUM_W = PEND_W + 2;

    logic [PEND_W-1:0] w_cnt  [NREG];
    logic [1:0]        w_kind [NREG];
    logic [NREG-1:0]   w_busy;

    logic              r_ex_valid;
    logic [4:0]        r_ex_rd;
    logic              r_sb_err;

    logic              w_issue_wr;
    logic [1:0]        w_new_kind;
    logic              w_flush_hit;
    logic              w_wb_hit;
    logic              w_long_hit;
    logic              w_load_hit;
    logic              w_sat_hit;
    logic [1:0]        w_cause;

    assign w_issue_wr  = sb.ID_issue & sb.ID_regWrite & (sb.ID_rd != 5'd0);
    assign w_new_kind  = sb.ID_longOp ? c_LONG : (sb.ID_memRead ? c_LOAD : c_FWD);
    assign w_flush_hit = sb.flush_ex & r_ex_valid & (r_ex_rd != 5'd0);
    assign w_wb_hit    = sb.WB_regWrite & (sb.WB_rd != 5'd0);

    // x0 is hardwired zero and never tracked.
    assign w_cnt[0]  = '0;
    assign w_kind[0] = c_FREE;

    generate
        for (genvar r = 1; r < NREG; r++) begin : g_reg
            logic [PEND_W-1:0]  r_cnt;
            logic [1:0]         r_kind;
            logic               w_iss;
            logic               w_wb;
            logic               w_fl;
            logic [c_SUM_W-1:0] w_sum;
            logic [PEND_W-1:0]  w_cnt_nxt;
            logic [1:0]         w_kind_nxt;

            always_comb begin
                w_iss = w_issue_wr  & (sb.ID_rd == 5'(r));
                // A retire or squash against an empty counter is ignored.
                w_wb  = w_wb_hit    & (sb.WB_rd == 5'(r)) & (r_cnt != '0);
                w_fl  = w_flush_hit & (r_ex_rd == 5'(r))  & (r_cnt != '0);

                // Issue, writeback and flush can coincide: sum the deltas.
                w_sum = c_SUM_W'(r_cnt) + c_SUM_W'(w_iss)
                      - c_SUM_W'(w_wb) - c_SUM_W'(w_fl);
                if (w_sum[c_SUM_W-1]) begin
                    w_cnt_nxt = '0;
                end else if (|w_sum[c_SUM_W-2:PEND_W]) begin
                    w_cnt_nxt = '1;
                end else begin
                    w_cnt_nxt = w_sum[PEND_W-1:0];
                end

                w_kind_nxt = r_kind;
                if (w_iss) begin
                    // Youngest writer defines how its consumers must wait.
                    w_kind_nxt = w_new_kind;
                end else if (w_cnt_nxt == '0) begin
                    w_kind_nxt = c_FREE;
                end else if (w_fl && ((r_kind == c_LOAD) || (r_kind == c_LONG))) begin
                    // The squashed producer was the slow one; older writers
                    // are far enough along to be forwarded.
                    w_kind_nxt = c_FWD;
                end else if (r_kind == c_LOAD) begin
                    // Load data reaches the forwarding path one cycle later.
                    w_kind_nxt = c_FWD;
                end
            end

            always_ff @(posedge clk) begin
                if (!reset_n) begin
                    r_cnt  <= '0;
                    r_kind <= c_FREE;
                end else begin
                    r_cnt  <= w_cnt_nxt;
                    r_kind <= w_kind_nxt;
                end
            end

            assign w_cnt[r]  = r_cnt;
            assign w_kind[r] = r_kind;
        end
    endgenerate

    always_comb begin
        for (int i = 0; i < NREG; i++) begin
            w_busy[i] = (w_cnt[i] != '0);
        end
    end

    // EX tracker: remembers the writer issued last cycle so a flush can undo it.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ex_valid <= 1'b0;
            r_ex_rd    <= 5'd0;
            r_sb_err   <= 1'b0;
        end else begin
            r_ex_valid <= w_issue_wr;
            r_ex_rd    <= sb.ID_rd;
            if (w_wb_hit && (w_cnt[sb.WB_rd] == '0)) begin
                r_sb_err <= 1'b1;
            end
        end
    end

    // Stall decision: purely combinational from ID fields and tracked state.
    always_comb begin
        w_long_hit = (sb.ID_useRs1 && (sb.ID_rs1 != 5'd0) && (w_kind[sb.ID_rs1] == c_LONG))
                  || (sb.ID_useRs2 && (sb.ID_rs2 != 5'd0) && (w_kind[sb.ID_rs2] == c_LONG))
                  || (sb.ID_regWrite && (sb.ID_rd != 5'd0) && (w_kind[sb.ID_rd] == c_LONG));
        w_load_hit = (sb.ID_useRs1 && (sb.ID_rs1 != 5'd0) && (w_kind[sb.ID_rs1] == c_LOAD))
                  || (sb.ID_useRs2 && (sb.ID_rs2 != 5'd0) && (w_kind[sb.ID_rs2] == c_LOAD));
        w_sat_hit  = sb.ID_regWrite && (sb.ID_rd != 5'd0) && (w_cnt[sb.ID_rd] == '1);

        w_cause = c_CAUSE_NONE;
        if (w_long_hit) begin
            w_cause = c_CAUSE_LONG;
        end else if (w_load_hit) begin
            w_cause = c_CAUSE_LOAD;
        end else if (w_sat_hit) begin
            w_cause = c_CAUSE_SAT;
        end
    end

    assign sb.stall_cause = w_cause;
    assign sb.stall       = |w_cause;
    assign sb.busy_vec    = w_busy;
    assign sb.sb_err      = r_sb_err;

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_scoreboard
// Description : Self-checking bench for hazard_scoreboard. A reference model
//               keeps the list of in-flight writers (in issue order) and
//               derives counts, kinds and the expected stall from it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_scoreboard;

    localparam int NREG   = 32;
    localparam int PEND_W = 2;
    localparam int CMAX   = (1 << PEND_W) - 1;

    localparam int K_FREE = 0;
    localparam int K_FWD  = 1;
    localparam int K_LOAD = 2;
    localparam int K_LONG = 3;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;

    always #5 clk = ~clk;

    hazard_scoreboard_if #(.NREG(NREG)) sb_if ();

    hazard_scoreboard #(
        .NREG   (NREG),
        .PEND_W (PEND_W)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .sb      (sb_if.slave)
    );

    typedef struct {
        int rd;
        bit ld;
        bit lg;
        int tag;
    } wr_t;

    wr_t q[$];
    int  cyc    = 0;
    bit  m_err  = 1'b0;
    int  n_chk  = 0;
    int  n_err  = 0;

    // ---------------- reference model ----------------
    function automatic int m_cnt(input int r);
        int n = 0;
        foreach (q[i]) if (q[i].rd == r) n++;
        return n;
    endfunction

    function automatic int m_kind(input int r);
        int k = K_FREE;
        foreach (q[i]) begin
            if (q[i].rd == r) begin
                if (q[i].lg)                          k = K_LONG;
                else if (q[i].ld && q[i].tag == cyc-1) k = K_LOAD;
                else                                   k = K_FWD;
            end
        end
        return k;
    endfunction

    function automatic logic [1:0] m_cause();
        int rs1 = int'(sb_if.ID_rs1);
        int rs2 = int'(sb_if.ID_rs2);
        int rd  = int'(sb_if.ID_rd);
        bit lng, lod, sat;
        lng = (sb_if.ID_useRs1 && rs1 != 0 && m_kind(rs1) == K_LONG)
           || (sb_if.ID_useRs2 && rs2 != 0 && m_kind(rs2) == K_LONG)
           || (sb_if.ID_regWrite && rd != 0 && m_kind(rd) == K_LONG);
        lod = (sb_if.ID_useRs1 && rs1 != 0 && m_kind(rs1) == K_LOAD)
           || (sb_if.ID_useRs2 && rs2 != 0 && m_kind(rs2) == K_LOAD);
        sat = sb_if.ID_regWrite && rd != 0 && m_cnt(rd) == CMAX;
        if (lng) return 2'b10;
        if (lod) return 2'b01;
        if (sat) return 2'b11;
        return 2'b00;
    endfunction

    function automatic logic [NREG-1:0] m_busy();
        logic [NREG-1:0] b = '0;
        for (int r = 1; r < NREG; r++) b[r] = (m_cnt(r) != 0);
        return b;
    endfunction

    task automatic model_update();
        int wrd = int'(sb_if.WB_rd);
        if (!reset_n) begin
            q.delete();
            m_err = 1'b0;
        end else begin
            if (sb_if.WB_regWrite && wrd != 0 && m_cnt(wrd) == 0) m_err = 1'b1;
            if (sb_if.flush_ex) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].tag == cyc - 1) begin
                        q.delete(i);
                        break;
                    end
                end
            end
            if (sb_if.WB_regWrite && wrd != 0) begin
                for (int i = 0; i < q.size(); i++) begin
                    if (q[i].rd == wrd) begin
                        q.delete(i);
                        break;
                    end
                end
            end
            if (sb_if.ID_issue && sb_if.ID_regWrite && sb_if.ID_rd != 5'd0)
                q.push_back('{rd: int'(sb_if.ID_rd), ld: sb_if.ID_memRead,
                              lg: sb_if.ID_longOp, tag: cyc});
        end
        cyc++;
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Checks the current cycle, then clocks it into DUT and model.
    task automatic step();
        #1;
        chk("stall_cause", 64'(sb_if.stall_cause), 64'(m_cause()));
        chk("stall", 64'(sb_if.stall), 64'(|m_cause()));
        chk("busy_vec", 64'(sb_if.busy_vec), 64'(m_busy()));
        chk("sb_err", 64'(sb_if.sb_err), 64'(m_err));
        chk("issue_while_stall", 64'(sb_if.ID_issue & sb_if.stall), 64'd0);
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        sb_if.ID_issue    = 1'b0;
        sb_if.ID_rs1      = 5'd0;
        sb_if.ID_rs2      = 5'd0;
        sb_if.ID_useRs1   = 1'b0;
        sb_if.ID_useRs2   = 1'b0;
        sb_if.ID_rd       = 5'd0;
        sb_if.ID_regWrite = 1'b0;
        sb_if.ID_memRead  = 1'b0;
        sb_if.ID_longOp   = 1'b0;
        sb_if.flush_ex    = 1'b0;
        sb_if.WB_regWrite = 1'b0;
        sb_if.WB_rd       = 5'd0;
    endtask

    task automatic set_wr(input bit iss, input int rd, input bit ld, input bit lg);
        sb_if.ID_issue    = iss;
        sb_if.ID_rd       = 5'(rd);
        sb_if.ID_regWrite = 1'b1;
        sb_if.ID_memRead  = ld;
        sb_if.ID_longOp   = lg;
    endtask

    task automatic set_wb(input int rd);
        sb_if.WB_regWrite = 1'b1;
        sb_if.WB_rd       = 5'(rd);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int idx[$];
        idle();
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        step();                                       // reset state

        // Load-use: lw x5, then consumer of x5 stalls exactly one cycle.
        set_wr(1'b1, 5, 1'b1, 1'b0); step();
        idle(); sb_if.ID_rs1 = 5'd5; sb_if.ID_useRs1 = 1'b1; set_wr(1'b0, 6, 1'b0, 1'b0);
        #1 chk("loaduse_cause", 64'(sb_if.stall_cause), 64'h1);
        step();
        sb_if.ID_issue = 1'b1;
        #1 chk("loaduse_cleared", 64'(sb_if.stall), 64'h0);
        step();

        // Long op: div x7, RAW consumer held until its writeback.
        idle(); set_wr(1'b1, 7, 1'b0, 1'b1); step();
        idle(); sb_if.ID_rs2 = 5'd7; sb_if.ID_useRs2 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1 chk("longop_raw", 64'(sb_if.stall_cause), 64'h2);
            step();
        end
        idle(); set_wr(1'b0, 7, 1'b0, 1'b0);
        #1 chk("longop_waw", 64'(sb_if.stall_cause), 64'h2);
        step();
        idle(); sb_if.ID_rs2 = 5'd7; sb_if.ID_useRs2 = 1'b1; set_wb(7);
        step();
        idle(); sb_if.ID_rs2 = 5'd7; sb_if.ID_useRs2 = 1'b1;
        #1 chk("longop_released", 64'(sb_if.stall), 64'h0);
        step();

        // Retire the earlier x5/x6 writers.
        idle(); set_wb(5); step();
        idle(); set_wb(6); step();

        // Two ALU writes to x3, retired one by one.
        idle(); set_wr(1'b1, 3, 1'b0, 1'b0); step();
        step();
        idle();
        #1 chk("x3_two_writers", 64'(sb_if.busy_vec[3]), 64'h1);
        set_wb(3); step();
        idle();
        #1 chk("x3_after_first_wb", 64'(sb_if.busy_vec[3]), 64'h1);
        set_wb(3); step();
        idle();
        #1 chk("x3_after_second_wb", 64'(sb_if.busy_vec[3]), 64'h0);

        // Squashed load: lw x9 flushed in EX.
        set_wr(1'b1, 9, 1'b1, 1'b0); step();
        idle(); sb_if.flush_ex = 1'b1; step();
        idle(); sb_if.ID_rs1 = 5'd9; sb_if.ID_useRs1 = 1'b1;
        #1 chk("flush_busy9", 64'(sb_if.busy_vec[9]), 64'h0);
        chk("flush_nostall", 64'(sb_if.stall), 64'h0);
        step();

        // x0 writes are ignored; stray writeback sets sticky error.
        idle(); set_wr(1'b1, 0, 1'b1, 1'b0); step();
        idle();
        #1 chk("x0_untracked", 64'(sb_if.busy_vec), 64'h0);
        set_wb(4); step();
        idle();
        #1 chk("sb_err_set", 64'(sb_if.sb_err), 64'h1);
        for (int i = 0; i < 3; i++) begin
            idle(); set_wr(1'b1, 4, 1'b0, 1'b0); step();
        end
        idle(); set_wr(1'b0, 4, 1'b0, 1'b0);
        #1 chk("saturated_cause", 64'(sb_if.stall_cause), 64'h3);
        step();
        idle();
        #1 chk("sb_err_held", 64'(sb_if.sb_err), 64'h1);

        // Reset in the middle of traffic discards everything.
        set_wr(1'b1, 8, 1'b0, 1'b1); step();
        idle(); reset_n = 1'b0; set_wr(1'b1, 10, 1'b1, 1'b0); step();
        idle(); reset_n = 1'b1;
        #1 chk("reset_busy", 64'(sb_if.busy_vec), 64'h0);
        chk("reset_stall", 64'(sb_if.stall), 64'h0);
        chk("reset_sb_err", 64'(sb_if.sb_err), 64'h0);
        step();

        // Randomized traffic on a small register window to force collisions.
        for (int n = 0; n < 3000; n++) begin
            int k;
            idle();
            reset_n           = ($urandom_range(0, 499) != 0);
            sb_if.ID_rs1      = 5'($urandom_range(0, 7));
            sb_if.ID_rs2      = 5'($urandom_range(0, 7));
            sb_if.ID_useRs1   = 1'($urandom_range(0, 1));
            sb_if.ID_useRs2   = 1'($urandom_range(0, 1));
            sb_if.ID_rd       = 5'($urandom_range(0, 7));
            sb_if.ID_regWrite = ($urandom_range(0, 3) != 0);
            k                 = int'($urandom_range(0, 9));
            sb_if.ID_longOp   = (k == 0);
            sb_if.ID_memRead  = (k >= 1 && k <= 3);
            idx.delete();
            foreach (q[i]) if (q[i].tag <= cyc - 2) idx.push_back(i);
            if (idx.size() > 0 && $urandom_range(0, 1) == 1)
                set_wb(q[idx[$urandom_range(0, idx.size() - 1)]].rd);
            sb_if.flush_ex    = ($urandom_range(0, 7) == 0);
            sb_if.ID_issue    = ($urandom_range(0, 3) != 0) && (m_cause() == 2'b00);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
